// File: rtl/rf_wb_pkg.sv
// ==========================================================================
// rf_wb_pkg: shared defaults and the aux queue entry layout. Rev 1.0
// ==========================================================================
`default_nettype none

package rf_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef struct packed {
    logic                  live;
    logic [ADDR_W_DEF-1:0] waddr;
    logic [DATA_W_DEF-1:0] wdata;
  } rf_wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_aux_fifo.sv
// ==========================================================================
// wb_aux_fifo: circular aux result queue with kill-by-address and pend_mask. Rev 1.0
// ==========================================================================
`default_nettype none

module wb_aux_fifo
  import rf_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_waddr,
  input  logic [DATA_W-1:0]         push_wdata,
  input  logic                      pop,
  input  logic                      kill,
  input  logic [ADDR_W-1:0]         kill_waddr,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      head_valid,
  output logic                      head_live,
  output logic [ADDR_W-1:0]         head_waddr,
  output logic [DATA_W-1:0]         head_wdata,
  output logic [2**ADDR_W-1:0]      pend_mask
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill && (mem_q[i].waddr == kill_waddr)) mem_d[i].live = 1'b0;
    end
    // Popped slots drop their live bit so pend_mask only needs to scan live flags.
    if (pop) mem_d[rd_ptr_q].live = 1'b0;
    // A same-cycle enqueue overrides the kill: it is younger than the pipeline write.
    if (push) begin
      mem_d[wr_ptr_q].live  = (push_waddr != '0);
      mem_d[wr_ptr_q].waddr = push_waddr;
      mem_d[wr_ptr_q].wdata = push_wdata;
    end
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].live) pend_mask[mem_q[i].waddr] = 1'b1;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_live  = head_valid && mem_q[rd_ptr_q].live;
  assign head_waddr = mem_q[rd_ptr_q].waddr;
  assign head_wdata = mem_q[rd_ptr_q].wdata;

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ==========================================================================
// rf_wb_arbiter: shares the RF write port between writeback and mul/div results. Rev 1.0
// ==========================================================================
`default_nettype none

module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_we,
  input  logic [ADDR_W-1:0]    pipe_waddr,
  input  logic [DATA_W-1:0]    pipe_wdata,
  input  logic                 aux_valid,
  output logic                 aux_ready,
  input  logic [ADDR_W-1:0]    aux_waddr,
  input  logic [DATA_W-1:0]    aux_wdata,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 stall_req,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic                 err_collision
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [PTR_W:0]      fifo_count;
  logic                head_valid, head_live;
  logic [ADDR_W-1:0]   head_waddr;
  logic [DATA_W-1:0]   head_wdata;
  logic [2**ADDR_W-1:0] fifo_pend;

  logic                pipe_req, grant_pipe, grant_aux, push, pop;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                err_q, err_d;

  assign aux_ready = !reset && (fifo_count < (PTR_W+1)'(DEPTH));
  assign push      = aux_valid && aux_ready;
  assign stall_req = !reset && (starve_q == CNT_W'(STARVE_MAX));
  assign pipe_req  = pipe_we && (pipe_waddr != '0);

  always_comb begin
    grant_pipe = !stall_req && pipe_req;
    grant_aux  = head_live && (stall_req || !pipe_req);
    // A dead head leaves the queue without taking the write port.
    pop        = head_valid && (!head_live || grant_aux);

    rf_we_d    = grant_pipe || grant_aux;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    if (grant_pipe) begin
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (grant_aux) begin
      rf_waddr_d = head_waddr;
      rf_wdata_d = head_wdata;
    end

    starve_d = '0;
    if (head_live && !grant_aux) begin
      starve_d = (starve_q == CNT_W'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end

    err_d = err_q || (pipe_we && stall_req);
  end

  wb_aux_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_waddr (aux_waddr),
    .push_wdata (aux_wdata),
    .pop        (pop),
    .kill       (grant_pipe),
    .kill_waddr (pipe_waddr),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_live  (head_live),
    .head_waddr (head_waddr),
    .head_wdata (head_wdata),
    .pend_mask  (fifo_pend)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign err_collision = err_q;
  assign pend_mask     = reset ? '0 : fifo_pend;

endmodule

`default_nettype wire
